multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//   Parametrised multi-cycle control sequencer for the SIMPLE core. Replaces the purely
//   combinational decode with an FSM that steps each instruction through IF/ID/EX/MEM/WB.
//   Phase-gated strobes drive PC, IR, register file and data memory; the block honours a
//   memory wait handshake, handles run/stop via exec and HLT, and counts retired instructions.
// PARAMETERS
//   INSTR_W   16  instruction width, >=16; op1=instr[W-1:W-2], op2=instr[W-3:W-5], op3=instr[7:4]
//   CNT_W     16  width of retired-instruction counter
//   MEM_WAIT   1  1: IF/MEM wait on mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
//   clock      in   1        system clock, all state on rising edge
//   reset      in   1        synchronous, active-high
//   exec       in   1        1-cycle pulse: start when IDLE/HALT, request stop when running
//   instr      in   INSTR_W  current IR contents, stable from ID through WB
//   mem_ready  in   1        memory access complete this cycle
//   IRWrite    out  1        load IR from memory (IF)
//   PCWrite    out  1        update PC this cycle
//   PCSrc      out  1        0: PC+1, 1: branch target (valid while PCWrite=1)
//   MemRead    out  1        data read request (IF fetch and LD in MEM)
//   MemWrite   out  1        data write request (ST in MEM)
//   RegWrite   out  1        register file write strobe (WB only)
//   MemtoReg   out  1        WB data from memory (LD)
//   RegDst     out  1        dest reg field select (1 except LD)
//   ALUSrc     out  1        ALU B from immediate (op3[3:2]==2'b10)
//   running    out  1        FSM in IF..WB
//   halted     out  1        FSM in HALT
//   retired    out  CNT_W    retired-instruction count
// BEHAVIOUR
//   Reset: state=IDLE, stop_req=0, retired=0; all strobes and running/halted =0.
//   Decode (comb, from instr): LD op1=00 & instr!=0; ST op1=01; LI op1=10,op2=000;
//     BR op1=10,op2 in {100,111}; ALU op1=11 except op3 in {0101 CMP,1101 OUT,1111 HLT};
//     HLT op1=11,op3=1111; NOP instr==0. wb_needed = LD|LI|ALU.
//   MemtoReg/RegDst/ALUSrc: level signals from decode, meaningful ID..WB only.
//   States/transitions (one per clock unless waiting):
//     IDLE: exec -> IF. HALT: exec -> IF (resume at current PC); halted=1.
//     IF:   MemRead=1; when mem_ready: IRWrite=1, PCWrite=1, PCSrc=0 -> ID; else stay.
//     ID:   NOP/CMP/OUT -> retire; HLT -> retire, then HALT; else -> EX.
//     EX:   BR: PCWrite=1, PCSrc=1, retire; LD/ST -> MEM; wb_needed -> WB.
//     MEM:  LD: MemRead=1; ST: MemWrite=1; held until mem_ready; then LD -> WB, ST retire.
//     WB:   RegWrite=1 exactly one cycle, retire.
//   Retire: retired+=1 (wraps 2^CNT_W-1 -> 0); next = IDLE if stop_req|exec this cycle,
//     else IF; stop_req cleared on entering IDLE.
//   exec while running sets stop_req; current instruction always completes (no abort).
//   exec in IDLE/HALT the same cycle as reset: reset wins.
//   Reset mid-instruction: return to IDLE next edge, strobes drop that cycle, partial
//     MEM write is the memory's concern (MemWrite deasserts immediately).
//   At most one of RegWrite/MemWrite/IRWrite high in any cycle.
//   Latency (mem_ready=1): ALU/LI/LD-less 4 cycles, LD 5, ST 4, BR 3, NOP/HLT 2.
// TESTING
//   reset held 2 cycles -> every output 0, retired=0, running=0, halted=0.
//   exec, instr=16'hC100 (ADD), mem_ready=1 -> IF,ID,EX,WB; RegWrite=1 only in cycle 4;
//     RegDst=1, MemtoReg=0; retired=1; then IF again.
//   instr=16'h0104 (LD), mem_ready low 3 cycles in MEM -> MemRead held 4 cycles,
//     WB one cycle later with MemtoReg=1, RegDst=0.
//   instr=16'hA005 (BR) -> EX asserts PCWrite=1,PCSrc=1 for 1 cycle, no RegWrite.
//   instr=16'hC0F0 (HLT) -> halted=1 after ID, holds indefinitely; exec -> IF next cycle.
//   exec pulse during EX of ADD -> WB completes, retired increments, state IDLE; with
//     CNT_W=4 and 16 retirements -> retired wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Purpose : multi-cycle IF/ID/EX/MEM/WB control sequencer for the SIMPLE core, with
//           phase-gated PC/IR/regfile/memory strobes, run/stop control and a retire counter.
// Latency : with mem_ready=1: ALU/LI 4, LD 5, ST 4, BR 3, NOP/CMP/OUT/HLT 2 cycles per instruction.
// Backpr. : IF and MEM stall while mem_ready=0 (when MEM_WAIT=1); exec while running only
//           requests a stop, which takes effect once the current instruction has retired.
// Ports   : clock/reset (sync, active-high); exec start/stop pulse; instr = IR contents
//           (stable ID..WB); mem_ready memory handshake; IRWrite/PCWrite/PCSrc/MemRead/
//           MemWrite/RegWrite strobes; MemtoReg/RegDst/ALUSrc datapath selects (valid ID..WB);
//           running/halted status; retired instruction count.
module multicycle_controller #(
    parameter int INSTR_W  = 16,
    parameter int CNT_W    = 16,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               ALUSrc,
    output logic               running,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    logic [2:0] state;
    logic [2:0] state_nx;
    logic       stop_req;
    logic       retire;
    logic       mem_ok;
    logic       in_phase;

    logic       ir_wr, pc_wr, pc_src, mem_rd, mem_wr, reg_wr;

    // Instruction decode (meaningful only while the IR holds the current instruction)
    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] op3;
    logic       is_nop, is_ld, is_st, is_li, is_br, is_alu, is_hlt, is_cmpout, wb_needed;

    assign op1 = instr[INSTR_W-1 -: 2];
    assign op2 = instr[INSTR_W-3 -: 3];
    assign op3 = instr[7:4];

    assign is_nop    = (instr == '0);
    assign is_ld     = (op1 == 2'b00) && !is_nop;
    assign is_st     = (op1 == 2'b01);
    assign is_li     = (op1 == 2'b10) && (op2 == 3'b000);
    assign is_br     = (op1 == 2'b10) && ((op2 == 3'b100) || (op2 == 3'b111));
    assign is_hlt    = (op1 == 2'b11) && (op3 == 4'b1111);
    assign is_cmpout = (op1 == 2'b11) && ((op3 == 4'b0101) || (op3 == 4'b1101));
    assign is_alu    = (op1 == 2'b11) && !is_hlt && !is_cmpout;
    assign wb_needed = is_ld || is_li || is_alu;

    // With MEM_WAIT=0 the memory is assumed single-cycle and the handshake is ignored
    assign mem_ok = !MEM_WAIT || mem_ready;

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        pc_src   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        reg_wr   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (exec) state_nx = S_IF;
            end
            S_IF: begin
                mem_rd = 1'b1;
                if (mem_ok) begin
                    ir_wr    = 1'b1;
                    pc_wr    = 1'b1;
                    state_nx = S_ID;
                end
            end
            S_ID: begin
                if (is_nop || is_cmpout || is_hlt) retire = 1'b1;
                else                               state_nx = S_EX;
            end
            S_EX: begin
                if (is_br) begin
                    pc_wr  = 1'b1;
                    pc_src = 1'b1;
                    retire = 1'b1;
                end else if (is_ld || is_st) begin
                    state_nx = S_MEM;
                end else if (wb_needed) begin
                    state_nx = S_WB;
                end else begin
                    // Undefined op1=10 encodings have no effect and simply retire
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                mem_rd = is_ld;
                mem_wr = is_st;
                if (mem_ok) begin
                    if (is_ld) state_nx = S_WB;
                    else       retire   = 1'b1;
                end
            end
            S_WB: begin
                reg_wr = 1'b1;
                retire = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase

        // A pending stop or an exec arriving in the retire cycle itself ends the run
        if (retire) begin
            if (state == S_ID && is_hlt)  state_nx = S_HALT;
            else if (stop_req || exec)    state_nx = S_IDLE;
            else                          state_nx = S_IF;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            stop_req <= 1'b0;
            retired  <= '0;
        end else begin
            state <= state_nx;
            if (retire) retired <= retired + CNT_W'(1);
            // Leaving the run for IDLE or HALT consumes any outstanding stop request
            if (state_nx == S_IDLE || state_nx == S_HALT) stop_req <= 1'b0;
            else if (exec && running)                     stop_req <= 1'b1;
        end
    end

    assign in_phase = (state == S_ID) || (state == S_EX) || (state == S_MEM) || (state == S_WB);
    assign running  = (state == S_IF) || in_phase;
    assign halted   = (state == S_HALT);

    // Strobes drop in the reset cycle itself so no partial access continues
    assign IRWrite  = ir_wr  && !reset;
    assign PCWrite  = pc_wr  && !reset;
    assign PCSrc    = pc_src && !reset;
    assign MemRead  = mem_rd && !reset;
    assign MemWrite = mem_wr && !reset;
    assign RegWrite = reg_wr && !reset;

    assign MemtoReg = in_phase && is_ld;
    assign RegDst   = in_phase && !is_ld;
    assign ALUSrc   = in_phase && (op3[3:2] == 2'b10);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset, exec, mem_ready;
    logic [15:0] instr;
    logic        IRWrite, PCWrite, PCSrc, MemRead, MemWrite, RegWrite;
    logic        MemtoReg, RegDst, ALUSrc, running, halted;
    logic [3:0]  retired;

    always #5 clock = ~clock;

    multicycle_controller #(.INSTR_W(16), .CNT_W(4), .MEM_WAIT(1'b1)) dut (
        .clock(clock), .reset(reset), .exec(exec), .instr(instr), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .running(running), .halted(halted), .retired(retired)
    );

    // Output bit order: IRWrite PCWrite PCSrc MemRead MemWrite RegWrite MemtoReg RegDst ALUSrc running halted
    localparam logic [10:0] Z     = 11'b00000000000;
    localparam logic [10:0] F_IF  = 11'b11010000010;
    localparam logic [10:0] F_STL = 11'b00010000010;
    localparam logic [10:0] L_STD = 11'b00000001010;
    localparam logic [10:0] L_LD  = 11'b00000010010;
    localparam logic [10:0] MR    = 11'b00010000000;
    localparam logic [10:0] MW    = 11'b00001000000;
    localparam logic [10:0] RW    = 11'b00000100000;
    localparam logic [10:0] PCBR  = 11'b01100000000;
    localparam logic [10:0] ASRC  = 11'b00000000100;
    localparam logic [10:0] HLTD  = 11'b00000000001;

    typedef struct {
        logic        rst;
        logic        ex;
        logic [15:0] ins;
        logic        rdy;
        logic [10:0] bits;
        logic [3:0]  ret;
    } vec_t;

    typedef struct {
        int          idx;
        logic [10:0] bits;
        logic [3:0]  ret;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic e, input logic [15:0] i, input logic rdy,
                       input logic [10:0] b, input logic [3:0] ret);
        vec_t v;
        v.rst = r; v.ex = e; v.ins = i; v.rdy = rdy; v.bits = b; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin
        int n_stall, reads, stalls, wb, cyc;
        exp_t e, got;
        logic [10:0] outs;

        reset = 1'b1; exec = 1'b0; instr = 16'h0000; mem_ready = 1'b1;
        @(posedge clock); #1;

        // Reset held; exec during reset is ignored; IDLE holds without exec
        add(1, 0, 16'h0000, 1, Z, 0);
        add(1, 1, 16'h0000, 1, Z, 0);
        add(0, 0, 16'hC100, 1, Z, 0);
        // ADD: IF ID EX WB, RegWrite only in WB
        add(0, 1, 16'hC100, 1, Z, 0);
        add(0, 0, 16'hC100, 1, F_IF, 0);
        add(0, 0, 16'hC100, 1, L_STD, 0);
        add(0, 0, 16'hC100, 1, L_STD, 0);
        add(0, 0, 16'hC100, 1, L_STD | RW, 0);
        // LD with three wait cycles in MEM
        add(0, 0, 16'h0104, 1, F_IF, 1);
        add(0, 0, 16'h0104, 1, L_LD, 1);
        add(0, 0, 16'h0104, 1, L_LD, 1);
        add(0, 0, 16'h0104, 0, L_LD | MR, 1);
        add(0, 0, 16'h0104, 0, L_LD | MR, 1);
        add(0, 0, 16'h0104, 0, L_LD | MR, 1);
        add(0, 0, 16'h0104, 1, L_LD | MR, 1);
        add(0, 0, 16'h0104, 1, L_LD | RW, 1);
        // BR with a one-cycle fetch stall
        add(0, 0, 16'hA005, 0, F_STL, 2);
        add(0, 0, 16'hA005, 1, F_IF, 2);
        add(0, 0, 16'hA005, 1, L_STD, 2);
        add(0, 0, 16'hA005, 1, L_STD | PCBR, 2);
        // ST with one wait cycle
        add(0, 0, 16'h4000, 1, F_IF, 3);
        add(0, 0, 16'h4000, 1, L_STD, 3);
        add(0, 0, 16'h4000, 1, L_STD, 3);
        add(0, 0, 16'h4000, 0, L_STD | MW, 3);
        add(0, 0, 16'h4000, 1, L_STD | MW, 3);
        // ALU immediate, stop requested during EX: WB completes then IDLE
        add(0, 0, 16'hC1A0, 1, F_IF, 4);
        add(0, 0, 16'hC1A0, 1, L_STD | ASRC, 4);
        add(0, 1, 16'hC1A0, 1, L_STD | ASRC, 4);
        add(0, 0, 16'hC1A0, 1, L_STD | ASRC | RW, 4);
        add(0, 0, 16'hC1A0, 1, Z, 5);
        add(0, 0, 16'hC1A0, 1, Z, 5);
        // exec arriving in the retire cycle itself stops the run
        add(0, 1, 16'hC100, 1, Z, 5);
        add(0, 0, 16'hC100, 1, F_IF, 5);
        add(0, 0, 16'hC100, 1, L_STD, 5);
        add(0, 0, 16'hC100, 1, L_STD, 5);
        add(0, 1, 16'hC100, 1, L_STD | RW, 5);
        add(0, 0, 16'hC100, 1, Z, 6);
        // HLT: retires in ID, then HALT holds until exec
        add(0, 1, 16'hC0F0, 1, Z, 6);
        add(0, 0, 16'hC0F0, 1, F_IF, 6);
        add(0, 0, 16'hC0F0, 1, L_STD, 6);
        for (int k = 0; k < 8; k++) add(0, 0, 16'hC0F0, 1, HLTD, 7);
        add(0, 1, 16'hC0F0, 1, HLTD, 7);
        // Ten NOPs; counter wraps 15 -> 0; exec in the last retire cycle stops
        for (int k = 0; k < 10; k++) begin
            add(0, 0, 16'h0000, 1, F_IF, 4'(7 + k));
            add(0, (k == 9), 16'h0000, 1, L_STD, 4'(7 + k));
        end
        add(0, 0, 16'h0000, 1, Z, 1);
        // Reset during a stalled ST write: MemWrite drops in the reset cycle
        add(0, 1, 16'h4000, 1, Z, 1);
        add(0, 0, 16'h4000, 1, F_IF, 1);
        add(0, 0, 16'h4000, 1, L_STD, 1);
        add(0, 0, 16'h4000, 1, L_STD, 1);
        add(0, 0, 16'h4000, 0, L_STD | MW, 1);
        add(1, 0, 16'h4000, 0, L_STD, 1);
        add(0, 0, 16'h4000, 1, Z, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            reset = vecs[k].rst; exec = vecs[k].ex; instr = vecs[k].ins; mem_ready = vecs[k].rdy;
            e.idx = k; e.bits = vecs[k].bits; e.ret = vecs[k].ret;
            sb.push_back(e);
            @(negedge clock);
            got  = sb.pop_front();
            outs = {IRWrite, PCWrite, PCSrc, MemRead, MemWrite, RegWrite,
                    MemtoReg, RegDst, ALUSrc, running, halted};
            n_vec++;
            if (outs !== got.bits || retired !== got.ret) begin
                n_bad++;
                $display("FAIL vec%0d: outs=%b retired=%0d, expected outs=%b retired=%0d",
                         got.idx, outs, retired, got.bits, got.ret);
            end
            @(posedge clock); #1;
        end

        // LD with a random-length MEM stall, bounded wait for write-back
        n_stall = $urandom_range(1, 5);
        reads = 0; stalls = 0; wb = 0; cyc = 0;
        reset = 1'b0; exec = 1'b1; instr = 16'h0104; mem_ready = 1'b1;
        @(posedge clock); #1;
        exec = 1'b0;
        while (wb == 0 && cyc < 30) begin
            if (MemRead && MemtoReg) begin
                reads++;
                mem_ready = (stalls >= n_stall);
                stalls++;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clock);
            if (RegWrite) begin
                wb++;
                chk("ld_wb_memtoreg", 32'(MemtoReg), 1);
                chk("ld_wb_regdst", 32'(RegDst), 0);
            end
            @(posedge clock); #1;
            cyc++;
        end
        chk("ld_wb_seen", wb, 1);
        chk("ld_memread_cycles", reads, n_stall + 1);
        chk("ld_retired", 32'(retired), 1);
        chk("ld_refetch_running", 32'(running), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
